// File: rtl/led_bank_ctrl_if.sv
// Register bus for the LED bank controller: write strobe, address,
// write data and combinational readback.
interface led_bank_if;
  logic        We;
  logic [1:0]  Addr;
  logic [31:0] Din;
  logic [31:0] Dout;

  modport master (output We, output Addr, output Din, input Dout);
  modport slave  (input We, input Addr, input Din, output Dout);
endinterface

// File: rtl/led_bank_ctrl.sv
// LED bank controller: per-LED on/off and blink select, a shared blink
// prescaler producing phase PH, and a shared PWM brightness stage.
// Pad drive is registered, so register writes reach the pads one edge later.
module led_bank_ctrl #(
  parameter int WIDTH      = 16,
  parameter int ACTIVE_LOW = 1,
  parameter int PWM_BITS   = 4,
  parameter int DIV_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  led_bank_if.slave        bus,
  output logic [WIDTH-1:0] user_led
);

  // Pad pattern for "all LEDs off"; lit bits are XORed against it.
  localparam logic [WIDTH-1:0] LED_OFF = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  logic [WIDTH-1:0]    data_r;
  logic [WIDTH-1:0]    blink_en_r;
  logic [DIV_W-1:0]    div_r;
  logic [PWM_BITS-1:0] duty_r;
  logic [DIV_W-1:0]    presc_r;
  logic [PWM_BITS-1:0] pwm_r;
  logic                ph_r;

  logic                wr_data_s;
  logic                wr_blink_en_s;
  logic                wr_div_s;
  logic                wr_duty_s;
  logic                pwm_on_s;
  logic [WIDTH-1:0]    lit_s;

  // Decode the write strobe into one select per register.
  always_comb begin
    wr_data_s     = 1'b0;
    wr_blink_en_s = 1'b0;
    wr_div_s      = 1'b0;
    wr_duty_s     = 1'b0;
    if (bus.We) begin
      case (bus.Addr)
        2'd0:    wr_data_s     = 1'b1;
        2'd1:    wr_blink_en_s = 1'b1;
        2'd2:    wr_div_s      = 1'b1;
        2'd3:    wr_duty_s     = 1'b1;
        default: wr_data_s     = 1'b0;
      endcase
    end else begin
      wr_data_s = 1'b0;
    end
  end

  // Configuration registers; only the selected one loads, upper Din bits dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r     <= {WIDTH{1'b0}};
      blink_en_r <= {WIDTH{1'b0}};
      div_r      <= {DIV_W{1'b0}};
      duty_r     <= {PWM_BITS{1'b1}};
    end else begin
      if (wr_data_s)     data_r     <= bus.Din[WIDTH-1:0];
      if (wr_blink_en_s) blink_en_r <= bus.Din[WIDTH-1:0];
      if (wr_div_s)      div_r      <= bus.Din[DIV_W-1:0];
      if (wr_duty_s)     duty_r     <= bus.Din[PWM_BITS-1:0];
    end
  end

  // Blink prescaler: a divider write restarts the blink in the lit phase,
  // otherwise the count wraps at div_r and flips the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= {DIV_W{1'b0}};
      ph_r    <= 1'b1;
    end else if (wr_div_s) begin
      presc_r <= {DIV_W{1'b0}};
      ph_r    <= 1'b1;
    end else if (presc_r == div_r) begin
      presc_r <= {DIV_W{1'b0}};
      ph_r    <= ~ph_r;
    end else begin
      presc_r <= presc_r + DIV_W'(1);
    end
  end

  // Free-running PWM counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_r <= {PWM_BITS{1'b0}};
    end else begin
      pwm_r <= pwm_r + PWM_BITS'(1);
    end
  end

  // Brightness gate and per-channel lit state; all-ones duty means always on.
  always_comb begin
    pwm_on_s = (duty_r == {PWM_BITS{1'b1}}) || (pwm_r < duty_r);
    lit_s    = data_r & (~blink_en_r | {WIDTH{ph_r}}) & {WIDTH{pwm_on_s}};
  end

  // Registered pad drive, polarity applied via the off pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      user_led <= LED_OFF;
    end else begin
      user_led <= lit_s ^ LED_OFF;
    end
  end

  // Readback of the addressed register, zero-extended; independent of We.
  always_comb begin
    bus.Dout = 32'd0;
    case (bus.Addr)
      2'd0:    bus.Dout = 32'(data_r);
      2'd1:    bus.Dout = 32'(blink_en_r);
      2'd2:    bus.Dout = 32'(div_r);
      2'd3:    bus.Dout = 32'(duty_r);
      default: bus.Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_led_bank_ctrl.sv
// Scoreboard bench for led_bank_ctrl. Two instances share one register bus:
// the default build (16 LEDs, active-low) and an 8-LED active-high build.
// The reference model derives blink phase and PWM position from elapsed
// cycle counts rather than from counters and comparators.
module tb_led_bank_ctrl;

  logic        clk;
  logic        rst;
  logic [15:0] user_led;
  logic [7:0]  user_led2;

  led_bank_if bus ();
  led_bank_if bus2 ();

  assign bus2.We   = bus.We;
  assign bus2.Addr = bus.Addr;
  assign bus2.Din  = bus.Din;

  led_bank_ctrl dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .user_led(user_led)
  );

  led_bank_ctrl #(.WIDTH(8), .ACTIVE_LOW(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .user_led(user_led2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ul;
    logic [31:0] dout;
    logic [7:0]  ul2;
    logic [31:0] dout2;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [15:0] m_data, m_ben, m_div;
  logic [3:0]  m_duty;
  int          t_div, t_pwm;
  logic [15:0] m_ul;
  logic [7:0]  m_ul2;

  function automatic logic [15:0] model_lit();
    bit ph, on;
    ph = ((t_div / (int'(m_div) + 1)) % 2) == 0;
    on = (m_duty == 4'd15) || ((t_pwm % 16) < int'(m_duty));
    return m_data & (~m_ben | (ph ? 16'hFFFF : 16'h0000)) & (on ? 16'hFFFF : 16'h0000);
  endfunction

  task automatic model_reset();
    m_data = 16'h0; m_ben = 16'h0; m_div = 16'h0; m_duty = 4'hF;
    t_div = 0; t_pwm = 0; m_ul = 16'hFFFF; m_ul2 = 8'h00;
  endtask

  task automatic model_edge(input bit we, input logic [1:0] a, input logic [31:0] d);
    logic [15:0] lit;
    lit   = model_lit();
    m_ul  = ~lit;
    m_ul2 = lit[7:0];
    t_pwm++;
    t_div++;
    if (we) begin
      case (a)
        2'd0: m_data = d[15:0];
        2'd1: m_ben  = d[15:0];
        2'd2: begin m_div = d[15:0]; t_div = 0; end
        default: m_duty = d[3:0];
      endcase
    end
  endtask

  function automatic logic [31:0] model_dout(input logic [1:0] a, input bit narrow);
    logic [15:0] m;
    m = narrow ? 16'h00FF : 16'hFFFF;
    case (a)
      2'd0:    return {16'h0, m_data & m};
      2'd1:    return {16'h0, m_ben & m};
      2'd2:    return {16'h0, m_div};
      default: return {28'h0, m_duty};
    endcase
  endfunction

  // One bus cycle: drive just after an edge, log what the DUT should present
  // until the next edge, then advance the model across that edge.
  task automatic step(input bit r, input bit we, input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    rst = r; bus.We = we; bus.Addr = a; bus.Din = d;
    if (r) model_reset();
    e.ul = m_ul; e.dout = model_dout(a, 1'b0);
    e.ul2 = m_ul2; e.dout2 = model_dout(a, 1'b1);
    q.push_back(e);
    @(posedge clk);
    if (!r) model_edge(we, a, d);
    #1;
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, a, 32'h0);
  endtask

  // Monitor: compare every presented output against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks += 4;
      if (user_led !== e.ul) begin
        errors++; $display("FAIL user_led: got %h expected %h at %0t", user_led, e.ul, $time);
      end
      if (bus.Dout !== e.dout) begin
        errors++; $display("FAIL dout: got %h expected %h at %0t", bus.Dout, e.dout, $time);
      end
      if (user_led2 !== e.ul2) begin
        errors++; $display("FAIL user_led2: got %h expected %h at %0t", user_led2, e.ul2, $time);
      end
      if (bus2.Dout !== e.dout2) begin
        errors++; $display("FAIL dout2: got %h expected %h at %0t", bus2.Dout, e.dout2, $time);
      end
    end
  end

  initial begin
    rst = 1'b1; bus.We = 1'b0; bus.Addr = 2'd0; bus.Din = 32'h0;
    model_reset();
    @(posedge clk); #1;

    // Reset, with a write pulse that must be ignored
    step(1'b1, 1'b1, 2'd0, 32'hFFFF);
    step(1'b1, 1'b0, 2'd3, 32'h0);

    // Plain data write with default duty/blink
    step(1'b0, 1'b1, 2'd0, 32'h00A5);
    idle(4, 2'd0);

    // Blink on low nibble
    step(1'b0, 1'b1, 2'd0, 32'hFFFF);
    step(1'b0, 1'b1, 2'd1, 32'h000F);
    step(1'b0, 1'b1, 2'd2, 32'd3);
    idle(20, 2'd2);

    // Readback truncation
    step(1'b0, 1'b1, 2'd3, 32'hFFFFFFFF);
    idle(1, 2'd3);
    step(1'b0, 1'b1, 2'd2, 32'h00012345);
    idle(1, 2'd2);

    // PWM duty sweep
    step(1'b0, 1'b1, 2'd1, 32'h0);
    step(1'b0, 1'b1, 2'd3, 32'd4);
    step(1'b0, 1'b1, 2'd0, 32'h0001);
    idle(34, 2'd3);
    step(1'b0, 1'b1, 2'd3, 32'd0);
    idle(18, 2'd3);
    step(1'b0, 1'b1, 2'd3, 32'd15);
    idle(18, 2'd0);

    // Reset in the middle of an active blink, reading every register
    step(1'b0, 1'b1, 2'd0, 32'hFFFF);
    step(1'b0, 1'b1, 2'd1, 32'hFF0F);
    step(1'b0, 1'b1, 2'd2, 32'd2);
    idle(5, 2'd1);
    for (int a = 0; a < 4; a++) step(1'b1, 1'b0, 2'(a), 32'h0);
    step(1'b0, 1'b1, 2'd0, 32'h0081);
    idle(3, 2'd0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      bit          we, r;
      a  = 2'($urandom_range(0, 3));
      d  = $urandom();
      if (a == 2'd2 && ($urandom_range(0, 7) != 0)) d = 32'($urandom_range(0, 5));
      we = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 99) == 0);
      step(r, we, a, d);
    end
    step(1'b0, 1'b0, 2'd0, 32'h0);

    // Let the monitor drain, bounded
    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
